// File: rtl/mdu_ctrl_pkg.sv
// Shared constants for the multiply/divide unit: op one-hot layout,
// sequencer state encoding and a small two's-complement helper.
package mdu_ctrl_pkg;

    localparam int XLEN   = 32;
    localparam int MDOP_W = 8;
    localparam int CNT_W  = 6;

    // Bit positions inside the MDU op one-hot.
    localparam int OP_MULT  = 0;
    localparam int OP_MULTU = 1;
    localparam int OP_DIV   = 2;
    localparam int OP_DIVU  = 3;
    localparam int OP_MFHI  = 4;
    localparam int OP_MFLO  = 5;
    localparam int OP_MTHI  = 6;
    localparam int OP_MTLO  = 7;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_e;

    // Two's-complement negate when neg is set; used for operand magnitudes
    // and for the signed-divide result fixup.
    function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/mdu_ctrl_div.sv
// Restoring radix-2 divider datapath. Holds the partial remainder, the
// quotient/dividend shift register and the divisor. Sequenced entirely by
// start_i/step_i from the MDU controller; it has no state machine of its own.
module div_iter
    import mdu_ctrl_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o
);

    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // Trial subtraction of the divisor from the remainder shifted left by one.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {2'b00, dvs_q};
    end

    // Load operands on start; otherwise retire one quotient bit per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (start_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
        end else if (step_i) begin
            if (!diff[WIDTH+1]) begin
                rem_q <= diff[WIDTH:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= shifted[WIDTH:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quo_o = quo_q;
    assign rem_o = rem_q[WIDTH-1:0];

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the execute stage. Owns HI/LO, runs
// MULT/MULTU through a registered multiplier and DIV/DIVU through the
// iterative divider, and serves MFHI/MFLO/MTHI/MTLO in one cycle.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int DIV_STEPS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mdu_flush_i,
    input  logic              mdu_stall_i,
    input  logic [MDOP_W-1:0] mdu_op_i,
    input  logic [XLEN-1:0]   mdu_opr1_i,
    input  logic [XLEN-1:0]   mdu_opr2_i,
    output logic [XLEN-1:0]   mdu_res_o,
    output logic              mdu_stallreq_o,
    output logic [XLEN-1:0]   mdu_hi_o,
    output logic [XLEN-1:0]   mdu_lo_o
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

    mdu_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   mul_a_q;
    logic [XLEN-1:0]   mul_b_q;
    logic              mul_signed_q;
    logic [2*XLEN-1:0] prod_q;
    logic              is_div_q;
    logic              sign1_q;
    logic              sign2_q;

    logic              op_mul;
    logic              op_div;
    logic              div_start;
    logic              div_step;
    logic [XLEN-1:0]   div_dividend;
    logic [XLEN-1:0]   div_divisor;
    logic [XLEN-1:0]   div_quo;
    logic [XLEN-1:0]   div_rem;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [2*XLEN-1:0] mul_a_ext;
    logic [2*XLEN-1:0] mul_b_ext;

    assign op_mul = mdu_op_i[OP_MULT] | mdu_op_i[OP_MULTU];
    assign op_div = mdu_op_i[OP_DIV]  | mdu_op_i[OP_DIVU];

    // Divider sees operand magnitudes; signs are re-applied on the result.
    assign div_dividend = neg_if(mdu_op_i[OP_DIV] & mdu_opr1_i[XLEN-1], mdu_opr1_i);
    assign div_divisor  = neg_if(mdu_op_i[OP_DIV] & mdu_opr2_i[XLEN-1], mdu_opr2_i);
    assign div_start    = (state_q == MDU_IDLE) & op_div & ~mdu_flush_i;
    assign div_step     = (state_q == MDU_DIV) & ~mdu_flush_i;

    // Quotient flips when operand signs differ; remainder follows the dividend.
    assign quo_fix = neg_if(sign1_q ^ sign2_q, div_quo);
    assign rem_fix = neg_if(sign1_q, div_rem);

    // Sign- or zero-extend to 64 bits so one multiplier serves MULT and MULTU.
    assign mul_a_ext = {{XLEN{mul_signed_q & mul_a_q[XLEN-1]}}, mul_a_q};
    assign mul_b_ext = {{XLEN{mul_signed_q & mul_b_q[XLEN-1]}}, mul_b_q};

    div_iter #(
        .WIDTH(XLEN)
    ) u_div_iter (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .step_i     (div_step),
        .dividend_i (div_dividend),
        .divisor_i  (div_divisor),
        .quo_o      (div_quo),
        .rem_o      (div_rem)
    );

    // Sequencer: accepts MDU ops in IDLE, runs MUL/DIV, commits HI/LO from DONE.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all of them sample the same pre-edge values.
        if (rst) begin
            state_q      <= MDU_IDLE;
            cnt_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_signed_q <= 1'b0;
            prod_q       <= '0;
            is_div_q     <= 1'b0;
            sign1_q      <= 1'b0;
            sign2_q      <= 1'b0;
        end else if (mdu_flush_i) begin
            state_q <= MDU_IDLE;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (op_mul) begin
                        mul_a_q      <= mdu_opr1_i;
                        mul_b_q      <= mdu_opr2_i;
                        mul_signed_q <= mdu_op_i[OP_MULT];
                        is_div_q     <= 1'b0;
                        state_q      <= MDU_MUL;
                    end else if (op_div) begin
                        sign1_q  <= mdu_op_i[OP_DIV] & mdu_opr1_i[XLEN-1];
                        sign2_q  <= mdu_op_i[OP_DIV] & mdu_opr2_i[XLEN-1];
                        cnt_q    <= '0;
                        is_div_q <= 1'b1;
                        state_q  <= MDU_DIV;
                    end else if (!mdu_stall_i) begin
                        if (mdu_op_i[OP_MTHI]) hi_q <= mdu_opr1_i;
                        if (mdu_op_i[OP_MTLO]) lo_q <= mdu_opr1_i;
                    end
                end
                MDU_MUL: begin
                    prod_q  <= mul_a_ext * mul_b_ext;
                    state_q <= MDU_DONE;
                end
                MDU_DIV: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) state_q <= MDU_DONE;
                end
                MDU_DONE: begin
                    if (!mdu_stall_i) begin
                        hi_q    <= is_div_q ? rem_fix : prod_q[2*XLEN-1:XLEN];
                        lo_q    <= is_div_q ? quo_fix : prod_q[XLEN-1:0];
                        state_q <= MDU_IDLE;
                    end
                end
                default: state_q <= MDU_IDLE;
            endcase
        end
    end

    assign mdu_stallreq_o = ~mdu_flush_i &
                            (((state_q == MDU_IDLE) & (op_mul | op_div)) |
                             (state_q == MDU_MUL) | (state_q == MDU_DIV));

    // MFHI/MFLO read HI/LO directly; every other op returns zero.
    always_comb begin
        // NOTE: the default assignment keeps this block free of inferred latches.
        mdu_res_o = '0;
        if (mdu_op_i[OP_MFHI])      mdu_res_o = hi_q;
        else if (mdu_op_i[OP_MFLO]) mdu_res_o = lo_q;
    end

    assign mdu_hi_o = hi_q;
    assign mdu_lo_o = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus randomized ops
// compared with an arithmetic HI/LO reference model.
module tb_mdu_ctrl;

    localparam logic [7:0] MULT  = 8'h01;
    localparam logic [7:0] MULTU = 8'h02;
    localparam logic [7:0] DIV   = 8'h04;
    localparam logic [7:0] DIVU  = 8'h08;
    localparam logic [7:0] MFHI  = 8'h10;
    localparam logic [7:0] MFLO  = 8'h20;
    localparam logic [7:0] MTHI  = 8'h40;
    localparam logic [7:0] MTLO  = 8'h80;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        stall;
    logic [7:0]  op;
    logic [31:0] opr1;
    logic [31:0] opr2;
    logic [31:0] res;
    logic        stallreq;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_hi   = '0;
    logic [31:0] exp_lo   = '0;

    always #5 clk = ~clk;

    mdu_ctrl #(
        .DIV_STEPS(32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mdu_flush_i    (flush),
        .mdu_stall_i    (stall),
        .mdu_op_i       (op),
        .mdu_opr1_i     (opr1),
        .mdu_opr2_i     (opr2),
        .mdu_res_o      (res),
        .mdu_stallreq_o (stallreq),
        .mdu_hi_o       (hi),
        .mdu_lo_o       (lo)
    );

    // Reference HI/LO for multiply/divide ops, from plain integer arithmetic.
    function automatic logic [63:0] ref_hilo(input logic [7:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = '0;
        case (o)
            MULT:  p = sx * sy;
            MULTU: p = {32'd0, x} * {32'd0, y};
            DIVU:  p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            DIV: begin
                if (y == 0) begin
                    p = {x, (x[31] ? 32'd1 : 32'hFFFF_FFFF)};
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    // Present one op, count stall-request cycles, then advance past the
    // cycle where stallreq drops (commit edge when mdu_stall_i is low).
    task automatic run_op(input logic [7:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int stalls, output bit timeout, output logic [31:0] r,
                          output logic [31:0] pre_hi, output logic [31:0] pre_lo);
        op      = o;
        opr1    = x;
        opr2    = y;
        stalls  = 0;
        timeout = 1'b0;
        @(negedge clk);
        while (stallreq === 1'b1) begin
            stalls++;
            if (stalls > 100) begin
                timeout = 1'b1;
                break;
            end
            @(negedge clk);
        end
        r      = res;
        pre_hi = hi;
        pre_lo = lo;
        @(posedge clk);
        #1;
        op = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; stall = 1'b0; op = '0; opr1 = '0; opr2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
        n_checks++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL reset_stallreq: got %b expected 0", stallreq); end
        n_checks++; if (res !== 32'd0) begin n_fail++; $display("FAIL reset_res: got %h expected 0", res); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mult();
        int          st;
        bit          to;
        logic [31:0] r, ph, pl;
        run_op(MULT, 32'hFFFF_FFFE, 32'd3, st, to, r, ph, pl);
        n_checks++; if (to || st != 2) begin n_fail++; $display("FAIL mult_stall_cycles: got %0d (timeout %0d) expected 2", st, to); end
        n_checks++; if (ph !== exp_hi || pl !== exp_lo) begin n_fail++; $display("FAIL mult_early_write: got %h_%h expected %h_%h", ph, pl, exp_hi, exp_lo); end
        {exp_hi, exp_lo} = ref_hilo(MULT, 32'hFFFF_FFFE, 32'd3);
        n_checks++; if (hi !== exp_hi) begin n_fail++; $display("FAIL mult_hi: got %h expected %h", hi, exp_hi); end
        n_checks++; if (lo !== exp_lo) begin n_fail++; $display("FAIL mult_lo: got %h expected %h", lo, exp_lo); end
        run_op(MFLO, 32'd0, 32'd0, st, to, r, ph, pl);
        n_checks++; if (st != 0) begin n_fail++; $display("FAIL mflo_stall: got %0d expected 0", st); end
        n_checks++; if (r !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mflo_res: got %h expected fffffffa", r); end
    endtask

    task automatic test_div_directed();
        logic [7:0]  ops [5] = '{DIVU, DIV, DIV, DIVU, DIV};
        logic [31:0] xs  [5] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'hFFFF_FFF7};
        logic [31:0] ys  [5] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0};
        int          st;
        bit          to;
        logic [31:0] r, ph, pl;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], xs[i], ys[i], st, to, r, ph, pl);
            n_checks++; if (to || st != 33) begin n_fail++; $display("FAIL div%0d_stall_cycles: got %0d (timeout %0d) expected 33", i, st, to); end
            n_checks++; if (ph !== exp_hi || pl !== exp_lo) begin n_fail++; $display("FAIL div%0d_early_write: got %h_%h expected %h_%h", i, ph, pl, exp_hi, exp_lo); end
            {exp_hi, exp_lo} = ref_hilo(ops[i], xs[i], ys[i]);
            n_checks++; if (hi !== exp_hi) begin n_fail++; $display("FAIL div%0d_hi: got %h expected %h", i, hi, exp_hi); end
            n_checks++; if (lo !== exp_lo) begin n_fail++; $display("FAIL div%0d_lo: got %h expected %h", i, lo, exp_lo); end
        end
    endtask

    task automatic test_flush();
        int          st;
        bit          to;
        logic [31:0] r, ph, pl;
        run_op(MTHI, 32'h1234, 32'd0, st, to, r, ph, pl);
        exp_hi = 32'h1234;
        run_op(MTLO, 32'h55, 32'd0, st, to, r, ph, pl);
        exp_lo = 32'h55;
        op = DIV; opr1 = 32'd1000; opr2 = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        n_checks++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL flush_cycle_stallreq: got %b expected 0", stallreq); end
        @(posedge clk);
        #1;
        flush = 1'b0;
        op    = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL post_flush_stallreq: cycle %0d got %b expected 0", c, stallreq); end
            n_checks++; if (hi !== exp_hi || lo !== exp_lo) begin n_fail++; $display("FAIL post_flush_hilo: got %h_%h expected %h_%h", hi, lo, exp_hi, exp_lo); end
        end
        @(posedge clk);
        #1;
        run_op(MULT, 32'd7, 32'd6, st, to, r, ph, pl);
        {exp_hi, exp_lo} = ref_hilo(MULT, 32'd7, 32'd6);
        n_checks++; if (to || st != 2) begin n_fail++; $display("FAIL post_flush_mult_stall: got %0d expected 2", st); end
        n_checks++; if (hi !== exp_hi || lo !== exp_lo) begin n_fail++; $display("FAIL post_flush_mult_hilo: got %h_%h expected %h_%h", hi, lo, exp_hi, exp_lo); end
    endtask

    task automatic test_done_stall();
        int          st;
        logic [63:0] nxt;
        // Divide with the later stage stalled for four DONE cycles.
        op = DIVU; opr1 = 32'd1000; opr2 = 32'd9;
        st = 0;
        @(negedge clk);
        while (stallreq === 1'b1 && st <= 100) begin
            st++;
            @(negedge clk);
        end
        n_checks++; if (st != 33) begin n_fail++; $display("FAIL stall_div_cycles: got %0d expected 33", st); end
        stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            n_checks++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL done_hold_stallreq: cycle %0d got %b expected 0", c, stallreq); end
            n_checks++; if (hi !== exp_hi || lo !== exp_lo) begin n_fail++; $display("FAIL done_hold_hilo: cycle %0d got %h_%h expected %h_%h", c, hi, lo, exp_hi, exp_lo); end
        end
        stall = 1'b0;
        @(posedge clk);
        #1;
        op = '0;
        {exp_hi, exp_lo} = ref_hilo(DIVU, 32'd1000, 32'd9);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (hi !== exp_hi || lo !== exp_lo) begin n_fail++; $display("FAIL done_commit_hilo: cycle %0d got %h_%h expected %h_%h", c, hi, lo, exp_hi, exp_lo); end
            n_checks++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL done_commit_stallreq: cycle %0d got %b expected 0", c, stallreq); end
        end
        @(posedge clk);
        #1;
        // Flush together with stall in DONE: flush wins, nothing is written.
        op = DIVU; opr1 = 32'd50; opr2 = 32'd6;
        st = 0;
        @(negedge clk);
        while (stallreq === 1'b1 && st <= 100) begin
            st++;
            @(negedge clk);
        end
        n_checks++; if (st != 33) begin n_fail++; $display("FAIL flush_stall_div_cycles: got %0d expected 33", st); end
        stall = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        stall = 1'b0;
        flush = 1'b0;
        op    = '0;
        nxt   = ref_hilo(DIVU, 32'd50, 32'd6);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (hi !== exp_hi || lo !== exp_lo) begin n_fail++; $display("FAIL flush_in_done_hilo: cycle %0d got %h_%h expected %h_%h (not %h)", c, hi, lo, exp_hi, exp_lo, nxt); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_mul();
        int          st;
        bit          to;
        logic [31:0] r, ph, pl;
        run_op(MTLO, 32'h77, 32'd0, st, to, r, ph, pl);
        exp_lo = 32'h77;
        op = MULT; opr1 = 32'd5; opr2 = 32'd6;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        op  = '0;
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        n_checks++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL reset_mid_mul_hilo: got %h_%h expected 0_0", hi, lo); end
        n_checks++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL reset_mid_mul_stallreq: got %b expected 0", stallreq); end
        @(posedge clk);
        #1;
        run_op(MTLO, 32'hABCD, 32'd0, st, to, r, ph, pl);
        exp_lo = 32'hABCD;
        n_checks++; if (st != 0) begin n_fail++; $display("FAIL mtlo_stall: got %0d expected 0", st); end
        run_op(MFLO, 32'd0, 32'd0, st, to, r, ph, pl);
        n_checks++; if (st != 0 || r !== 32'hABCD) begin n_fail++; $display("FAIL mflo_after_reset: got %h (stalls %0d) expected 0000abcd (stalls 0)", r, st); end
    endtask

    task automatic test_random();
        int          st;
        int          exp_st;
        bit          to;
        logic [7:0]  o;
        logic [31:0] x, y, r, ph, pl, exp_res;
        for (int i = 0; i < 40; i++) begin
            o = 8'd1 << $urandom_range(0, 7);
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: y = $urandom_range(1, 15);
                2: x = 32'h8000_0000;
                default: ;
            endcase
            exp_res = (o == MFHI) ? exp_hi : (o == MFLO) ? exp_lo : 32'd0;
            exp_st  = (o == MULT || o == MULTU) ? 2 : (o == DIV || o == DIVU) ? 33 : 0;
            run_op(o, x, y, st, to, r, ph, pl);
            if (exp_st != 0) {exp_hi, exp_lo} = ref_hilo(o, x, y);
            else if (o == MTHI) exp_hi = x;
            else if (o == MTLO) exp_lo = x;
            n_checks++; if (to || st != exp_st) begin n_fail++; $display("FAIL rand%0d_stalls: op %h got %0d expected %0d", i, o, st, exp_st); end
            n_checks++; if (r !== exp_res) begin n_fail++; $display("FAIL rand%0d_res: op %h got %h expected %h", i, o, r, exp_res); end
            n_checks++; if (hi !== exp_hi || lo !== exp_lo) begin n_fail++; $display("FAIL rand%0d_hilo: op %h x %h y %h got %h_%h expected %h_%h", i, o, x, y, hi, lo, exp_hi, exp_lo); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mult();
        test_div_directed();
        test_flush();
        test_done_stall();
        test_reset_mid_mul();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
